// File: rtl/pcm_rom_arbiter.sv
// Shares one PCM sample ROM port between two ADPCM engines, each with a
// one-entry tag/data cache, round-robin arbitration and a fetch timeout.
module pcm_rom_arbiter #(
    parameter int            AW       = 20,
    parameter logic [AW-1:0] B_OFFSET = 'h40000,
    parameter int            TIMEOUT  = 255
) (
    input  logic          CLK96,
    input  logic          RESET96,
    input  logic [AW-1:0] A_ADDR,
    output logic [7:0]    A_DOUT,
    output logic          A_OK,
    input  logic [AW-1:0] B_ADDR,
    output logic [7:0]    B_DOUT,
    output logic          B_OK,
    output logic          ROM_CS,
    output logic [AW-1:0] ROM_ADDR,
    input  logic [7:0]    ROM_DOUT,
    input  logic          ROM_OK,
    output logic          ERR
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        WAIT
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t        st;
    logic [AW-1:0] tag_a;
    logic [AW-1:0] tag_b;
    logic [7:0]    data_a;
    logic [7:0]    data_b;
    logic          val_a;
    logic          val_b;
    logic          gnt_b;
    logic          last_b;
    logic [AW-1:0] req_tag;
    logic [7:0]    cnt;

    logic pend_a;
    logic pend_b;
    logic pick_b;

    assign A_OK   = val_a && (tag_a == A_ADDR);
    assign B_OK   = val_b && (tag_b == B_ADDR);
    assign A_DOUT = data_a;
    assign B_DOUT = data_b;

    assign pend_a = ~A_OK;
    assign pend_b = ~B_OK;
    // B wins when it is alone, or on a tie when A was served last
    assign pick_b = pend_b && (!pend_a || !last_b);

    always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96) begin
            st       <= IDLE;
            tag_a    <= '0;
            tag_b    <= '0;
            data_a   <= '0;
            data_b   <= '0;
            val_a    <= 1'b0;
            val_b    <= 1'b0;
            gnt_b    <= 1'b0;
            last_b   <= 1'b1;
            req_tag  <= '0;
            cnt      <= '0;
            ROM_CS   <= 1'b0;
            ROM_ADDR <= '0;
            ERR      <= 1'b0;
        end else begin
            unique case (st)
                IDLE: begin
                    if (pend_a || pend_b) begin
                        gnt_b    <= pick_b;
                        last_b   <= pick_b;
                        req_tag  <= pick_b ? B_ADDR : A_ADDR;
                        ROM_ADDR <= pick_b ? B_ADDR + B_OFFSET : A_ADDR;
                        ROM_CS   <= 1'b1;
                        st       <= SETTLE;
                    end
                end
                SETTLE: begin
                    cnt <= '0;
                    st  <= WAIT;
                end
                WAIT: begin
                    if (ROM_OK) begin
                        if (gnt_b) begin
                            data_b <= ROM_DOUT;
                            tag_b  <= req_tag;
                            val_b  <= 1'b1;
                        end else begin
                            data_a <= ROM_DOUT;
                            tag_a  <= req_tag;
                            val_a  <= 1'b1;
                        end
                        ROM_CS <= 1'b0;
                        st     <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        // abandon; cache untouched so the channel retries
                        ERR    <= 1'b1;
                        ROM_CS <= 1'b0;
                        st     <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pcm_rom_arbiter.sv
// Randomised and directed bench for pcm_rom_arbiter against a
// transaction-level cache/arbiter reference model.
module tb_pcm_rom_arbiter;

    localparam int         AW  = 20;
    localparam logic [19:0] OFF = 20'h40000;
    localparam int         TO  = 255;

    logic        CLK96    = 1'b0;
    logic        RESET96  = 1'b1;
    logic [19:0] A_ADDR   = '0;
    logic [19:0] B_ADDR   = '0;
    logic [7:0]  A_DOUT;
    logic [7:0]  B_DOUT;
    logic        A_OK;
    logic        B_OK;
    logic        ROM_CS;
    logic [19:0] ROM_ADDR;
    logic [7:0]  ROM_DOUT = '0;
    logic        ROM_OK   = 1'b0;
    logic        ERR;

    pcm_rom_arbiter #(
        .AW(AW),
        .B_OFFSET(OFF),
        .TIMEOUT(TO)
    ) dut (
        .CLK96(CLK96),
        .RESET96(RESET96),
        .A_ADDR(A_ADDR),
        .A_DOUT(A_DOUT),
        .A_OK(A_OK),
        .B_ADDR(B_ADDR),
        .B_DOUT(B_DOUT),
        .B_OK(B_OK),
        .ROM_CS(ROM_CS),
        .ROM_ADDR(ROM_ADDR),
        .ROM_DOUT(ROM_DOUT),
        .ROM_OK(ROM_OK),
        .ERR(ERR)
    );

    always #5 CLK96 = ~CLK96;

    int n_cmp = 0;
    int n_bad = 0;
    logic rst_drv = 1'b1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: per-channel cache plus one outstanding fetch record
    logic [19:0] m_tag [2];
    logic [7:0]  m_dat [2];
    logic        m_val [2];
    int          m_last;
    logic        m_busy;
    int          m_ch;
    logic [19:0] m_addr;
    logic [19:0] m_req;
    int          m_age;
    logic        m_err;

    task automatic m_reset();
        for (int c = 0; c < 2; c++) begin
            m_tag[c] = '0;
            m_dat[c] = '0;
            m_val[c] = 1'b0;
        end
        m_last = 1;
        m_busy = 1'b0;
        m_ch   = 0;
        m_addr = '0;
        m_req  = '0;
        m_age  = 0;
        m_err  = 1'b0;
    endtask

    function automatic logic m_ok(input int c);
        logic [19:0] a;
        a = (c == 1) ? B_ADDR : A_ADDR;
        return m_val[c] && (m_tag[c] == a);
    endfunction

    // m_age counts cycles since grant: 1 = settle, 2.. = waiting
    task automatic m_step();
        logic pa, pb;
        if (RESET96) begin
            m_reset();
            return;
        end
        pa = !m_ok(0);
        pb = !m_ok(1);
        if (!m_busy) begin
            if (pa || pb) begin
                m_ch   = (pb && (!pa || m_last == 0)) ? 1 : 0;
                m_last = m_ch;
                m_req  = (m_ch == 1) ? B_ADDR : A_ADDR;
                m_addr = (m_ch == 1) ? B_ADDR + OFF : A_ADDR;
                m_busy = 1'b1;
                m_age  = 1;
            end
        end else if (m_age == 1) begin
            m_age = 2;
        end else if (ROM_OK) begin
            m_dat[m_ch] = ROM_DOUT;
            m_tag[m_ch] = m_req;
            m_val[m_ch] = 1'b1;
            m_busy = 1'b0;
        end else if (m_age - 1 == TO) begin
            m_err  = 1'b1;
            m_busy = 1'b0;
        end else begin
            m_age++;
        end
    endtask

    task automatic compare_all();
        check("a_ok", 32'(A_OK), 32'(m_ok(0)));
        check("b_ok", 32'(B_OK), 32'(m_ok(1)));
        check("a_dout", 32'(A_DOUT), 32'(m_dat[0]));
        check("b_dout", 32'(B_DOUT), 32'(m_dat[1]));
        check("rom_cs", 32'(ROM_CS), 32'(m_busy));
        check("rom_addr", 32'(ROM_ADDR), 32'(m_addr));
        check("err", 32'(ERR), 32'(m_err));
    endtask

    task automatic cyc(input logic [19:0] a, input logic [19:0] b,
                       input logic ok, input logic [7:0] d);
        @(negedge CLK96);
        RESET96  = rst_drv;
        A_ADDR   = a;
        B_ADDR   = b;
        ROM_OK   = ok;
        ROM_DOUT = d;
        #1;
        if (RESET96) m_reset();
        compare_all();
        m_step();
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++)
            cyc(A_ADDR, B_ADDR, 1'b1, 8'($urandom));
    endtask

    int   hi;
    int   grants;
    logic err_early;
    logic exp_b;
    logic prev_cs;

    initial begin
        m_reset();
        rst_drv = 1'b1;
        cyc(20'h00010, 20'h0, 1'b0, 8'h0);
        cyc(20'h00010, 20'h0, 1'b0, 8'h0);
        check("rst_cs", 32'(ROM_CS), 32'd0);
        check("rst_addr", 32'(ROM_ADDR), 32'd0);
        check("rst_aok", 32'(A_OK), 32'd0);

        // first fetch latency
        rst_drv = 1'b0;
        cyc(20'h00010, 20'h0, 1'b0, 8'h0);
        cyc(20'h00010, 20'h0, 1'b0, 8'h0);
        check("t1_cs", 32'(ROM_CS), 32'd1);
        check("t1_addr", 32'(ROM_ADDR), 32'h00010);
        cyc(20'h00010, 20'h0, 1'b1, 8'h5A);
        cyc(20'h00010, 20'h0, 1'b0, 8'h0);
        check("t1_ok", 32'(A_OK), 32'd1);
        check("t1_dout", 32'(A_DOUT), 32'h5A);
        drain(8);

        // B offset and wrap
        cyc(A_ADDR, 20'h00020, 1'b1, 8'h33);
        cyc(A_ADDR, 20'h00020, 1'b1, 8'h33);
        check("t2_addr", 32'(ROM_ADDR), 32'h40020);
        drain(6);
        cyc(A_ADDR, 20'hFFFF0, 1'b1, 8'h44);
        cyc(A_ADDR, 20'hFFFF0, 1'b1, 8'h44);
        check("t3_addr", 32'(ROM_ADDR), 32'h3FFF0);
        drain(6);

        // both channels always pending: grants must alternate, A first
        exp_b   = 1'b0;
        grants  = 0;
        prev_cs = ROM_CS;
        for (int i = 0; i < 80 && grants < 8; i++) begin
            cyc(20'($urandom_range(0, 20'h3FFFF)),
                20'($urandom_range(0, 20'h3FFFF)), 1'b1, 8'($urandom));
            if (ROM_CS && !prev_cs) begin
                check("t4_grant", 32'(ROM_ADDR[18]), 32'(exp_b));
                exp_b = !exp_b;
                grants++;
            end
            prev_cs = ROM_CS;
        end
        check("t4_count", 32'(grants), 32'd8);
        drain(12);

        // address change mid-fetch
        cyc(20'h00100, B_ADDR, 1'b0, 8'h0);
        cyc(20'h00100, B_ADDR, 1'b0, 8'h0);
        check("t5_addr", 32'(ROM_ADDR), 32'h00100);
        cyc(20'h00100, B_ADDR, 1'b0, 8'h0);
        cyc(20'h00101, B_ADDR, 1'b0, 8'h0);
        cyc(20'h00101, B_ADDR, 1'b1, 8'h11);
        cyc(20'h00101, B_ADDR, 1'b0, 8'h0);
        check("t5_stale", 32'(A_OK), 32'd0);
        cyc(20'h00101, B_ADDR, 1'b1, 8'h22);
        check("t5_addr2", 32'(ROM_ADDR), 32'h00101);
        for (int i = 0; i < 5; i++)
            cyc(20'h00101, B_ADDR, 1'b1, 8'h22);
        check("t5_ok", 32'(A_OK), 32'd1);
        check("t5_dout", 32'(A_DOUT), 32'h22);

        // timeout
        hi        = 0;
        err_early = 1'b0;
        for (int i = 0; i < 400; i++) begin
            cyc(20'h00200, B_ADDR, 1'b0, 8'h0);
            if (ROM_CS) begin
                hi++;
                err_early = err_early | ERR;
            end else if (hi > 0) begin
                break;
            end
        end
        check("t6_hi", 32'(hi), 32'(TO + 1));
        check("t6_err_early", 32'(err_early), 32'd0);
        check("t6_err", 32'(ERR), 32'd1);
        cyc(20'h00200, B_ADDR, 1'b0, 8'h0);
        check("t6_retry_cs", 32'(ROM_CS), 32'd1);
        check("t6_retry_addr", 32'(ROM_ADDR), 32'h00200);
        cyc(20'h00200, B_ADDR, 1'b0, 8'h0);

        // reset while waiting
        rst_drv = 1'b1;
        cyc(20'h00200, B_ADDR, 1'b0, 8'h0);
        check("t7_cs", 32'(ROM_CS), 32'd0);
        check("t7_aok", 32'(A_OK), 32'd0);
        check("t7_bok", 32'(B_OK), 32'd0);
        check("t7_err", 32'(ERR), 32'd0);
        rst_drv = 1'b0;
        drain(10);

        // random traffic with small address pools to get cache hits
        for (int i = 0; i < 3000; i++) begin
            logic [19:0] na, nb;
            na = A_ADDR;
            nb = B_ADDR;
            if ($urandom_range(0, 5) == 0)
                na = 20'h00400 + 20'($urandom_range(0, 7));
            if ($urandom_range(0, 5) == 0)
                nb = ($urandom_range(0, 1) == 1)
                   ? 20'hFFFF8 + 20'($urandom_range(0, 7))
                   : 20'h00800 + 20'($urandom_range(0, 7));
            cyc(na, nb, 1'($urandom_range(0, 1)), 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
